// File: rtl/cpu_regfile_pkg.sv
// cpu_regfile_pkg: shared register select/destination encodings and P flag bit indices
package cpu_regfile_pkg;
    typedef enum logic [2:0] {RS_A, RS_X, RS_Y, RS_SP, RS_P, RS_DIN, RS_ZERO} reg_sel_t;
    typedef enum logic [2:0] {RD_NONE, RD_A, RD_X, RD_Y, RD_SP, RD_P} reg_dst_t;
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;
endpackage

// File: rtl/cpu_regfile_if.sv
// cpu_regfile_if: register file control/data bus between decoder+ALU (master) and register file (slave)
//  master drives: src1_sel, src2_sel, data_in, alu_out, alu_status, dst_sel, dst_from_din,
//                 status_we, sp_inc, sp_dec, brk_push
//  slave drives:  alu_in1, alu_in2, alu_p, reg_a, reg_x, reg_y, reg_sp, p_push, irq_mask
interface cpu_regfile_if;
    import cpu_regfile_pkg::*;
    reg_sel_t   src1_sel;
    reg_sel_t   src2_sel;
    logic [7:0] data_in;
    logic [7:0] alu_out;
    logic [7:0] alu_status;
    reg_dst_t   dst_sel;
    logic       dst_from_din;
    logic       status_we;
    logic       sp_inc;
    logic       sp_dec;
    logic       brk_push;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [7:0] alu_p;
    logic [7:0] reg_a;
    logic [7:0] reg_x;
    logic [7:0] reg_y;
    logic [7:0] reg_sp;
    logic [7:0] p_push;
    logic       irq_mask;
    modport master (
        output src1_sel, src2_sel, data_in, alu_out, alu_status, dst_sel, dst_from_din,
               status_we, sp_inc, sp_dec, brk_push,
        input  alu_in1, alu_in2, alu_p, reg_a, reg_x, reg_y, reg_sp, p_push, irq_mask
    );
    modport slave (
        input  src1_sel, src2_sel, data_in, alu_out, alu_status, dst_sel, dst_from_din,
               status_we, sp_inc, sp_dec, brk_push,
        output alu_in1, alu_in2, alu_p, reg_a, reg_x, reg_y, reg_sp, p_push, irq_mask
    );
endinterface

// File: rtl/cpu_regfile_operand_mux.sv
// cpu_operand_mux: selects one ALU operand from the registers or bus data
//  sel in 3 source select; a,x,y,sp,p,din in 8 candidates; out out 8 selected operand
module cpu_operand_mux
    import cpu_regfile_pkg::*;
(
    input  reg_sel_t   sel,
    input  logic [7:0] a,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] sp,
    input  logic [7:0] p,
    input  logic [7:0] din,
    output logic [7:0] out
);
    always_comb begin
        out = 8'h00;
        case (sel)
            RS_A:    out = a;
            RS_X:    out = x;
            RS_Y:    out = y;
            RS_SP:   out = sp;
            RS_P:    out = p;
            RS_DIN:  out = din;
            default: out = 8'h00;
        endcase
    end
endmodule

// File: rtl/cpu_regfile.sv
// cpu_regfile: 6502 A/X/Y/SP/P register file with ALU operand muxing, SP inc/dec and P push byte
//  clk, rst in 1 clock and synchronous active-high reset; bus slave modport carries all other signals
module cpu_regfile
    import cpu_regfile_pkg::*;
#(
    parameter logic [7:0] SP_RESET = 8'hFD,
    parameter logic [7:0] P_RESET  = 8'h34
)(
    input  logic         clk,
    input  logic         rst,
    cpu_regfile_if.slave bus
);
    logic [7:0] a, x, y, sp, p, wd;
    assign wd = bus.dst_from_din ? bus.data_in : bus.alu_out;
    cpu_operand_mux u_mux1 (.sel(bus.src1_sel), .a(a), .x(x), .y(y), .sp(sp), .p(p), .din(bus.data_in), .out(bus.alu_in1));
    cpu_operand_mux u_mux2 (.sel(bus.src2_sel), .a(a), .x(x), .y(y), .sp(sp), .p(p), .din(bus.data_in), .out(bus.alu_in2));
    always_ff @(posedge clk) begin
        if (rst) begin
            a  <= 8'h00;
            x  <= 8'h00;
            y  <= 8'h00;
            sp <= SP_RESET;
            p  <= P_RESET;
        end else begin
            if (bus.dst_sel == RD_A) a <= wd;
            if (bus.dst_sel == RD_X) x <= wd;
            if (bus.dst_sel == RD_Y) y <= wd;
            if (bus.dst_sel == RD_SP) sp <= wd;
            else if (bus.sp_inc ^ bus.sp_dec) sp <= bus.sp_inc ? sp + 8'd1 : sp - 8'd1;
            // pulled P never stores B; U always reads 1
            if (bus.dst_sel == RD_P) p <= {wd[7:6], 2'b10, wd[3:0]};
            else if (bus.status_we) p <= bus.alu_status | 8'h20;
        end
    end
    assign bus.alu_p    = p;
    assign bus.reg_a    = a;
    assign bus.reg_x    = x;
    assign bus.reg_y    = y;
    assign bus.reg_sp   = sp;
    assign bus.p_push   = {p[7:6], 1'b1, bus.brk_push, p[3:0]};
    assign bus.irq_mask = p[FLAG_I];
endmodule
